// File: rtl/alu_wb_pkg.sv
// Shared widths and FIFO operation encoding for the ALU writeback slice.
// Width defines are guarded so an existing globalVariables.v definition takes precedence.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package alu_wb_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifoOp_t;

  function automatic fifoOp_t decodeOp(input logic push, input logic pop);
    return fifoOp_t'({push, pop});
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Two-entry result buffer: storage, 1-bit wrapping pointers, occupancy and
// per-entry forwarding match flags.
module alu_wb_fifo
  import alu_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [DATA_WIDTH-1:0]          pushData,
  input  logic [REG_ADDR_WIDTH-1:0]      pushRd,
  input  logic [REG_ADDR_WIDTH-1:0]      fwdRd,
  output logic [DATA_WIDTH-1:0]          headData,
  output logic [REG_ADDR_WIDTH-1:0]      headRd,
  output logic [1:0]                     count,
  output logic [1:0]                     match,
  output logic [1:0][DATA_WIDTH-1:0]     entryData,
  output logic                           wrPtr
);

  logic [1:0][DATA_WIDTH-1:0]     dataMem;
  logic [1:0][REG_ADDR_WIDTH-1:0] rdMem;
  logic                           rdPtr;
  logic [1:0]                     entryValid;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: the storage is reset as well, because the head entry drives the
  // write-port data directly and must read as zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataMem <= '0;
      rdMem   <= '0;
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        dataMem[wrPtr] <= pushData;
        rdMem[wrPtr]   <= pushRd;
        wrPtr          <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case (decodeOp(push, pop))
        OP_PUSH: count <= count + 2'd1;
        OP_POP:  count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    entryValid = '0;
    case (count)
      2'd2:    entryValid = 2'b11;
      2'd1:    entryValid[rdPtr] = 1'b1;
      default: entryValid = '0;
    endcase
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < 2; i++) begin
      match[i] = entryValid[i] && (rdMem[i] == fwdRd);
    end
  end

  assign headData  = dataMem[rdPtr];
  assign headRd    = rdMem[rdPtr];
  assign entryData = dataMem;

endmodule

// File: rtl/alu_writeback.sv
// ALU result writeback stage: buffers results for the register-file write
// port, drops writes to x0 and forwards the youngest buffered match.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int DEPTH          = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [DATA_WIDTH-1:0]     inData,
  input  logic [REG_ADDR_WIDTH-1:0] inRd,
  output logic                      wbValid,
  input  logic                      wbReady,
  output logic [DATA_WIDTH-1:0]     wbData,
  output logic [REG_ADDR_WIDTH-1:0] wbRd,
  input  logic [REG_ADDR_WIDTH-1:0] fwdRd,
  output logic                      fwdHit,
  output logic [DATA_WIDTH-1:0]     fwdData,
  output logic [1:0]                occupancy
);

  logic                       push;
  logic                       pop;
  logic [1:0]                 match;
  logic [1:0][DATA_WIDTH-1:0] entryData;
  logic                       wrPtr;
  logic                       youngSlot;

  // Ready is a pure function of registered state (and reset), never of valid.
  assign inReady = reset_n && (occupancy != 2'(DEPTH));
  assign wbValid = (occupancy != 2'd0);
  assign push    = inValid && inReady && (inRd != '0);
  assign pop     = wbValid && wbReady;

  alu_wb_fifo #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .pushData  (inData),
    .pushRd    (inRd),
    .fwdRd     (fwdRd),
    .headData  (wbData),
    .headRd    (wbRd),
    .count     (occupancy),
    .match     (match),
    .entryData (entryData),
    .wrPtr     (wrPtr)
  );

  // The slot just behind the write pointer holds the most recent entry.
  assign youngSlot = ~wrPtr;

  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    if (fwdRd != '0) begin
      if (match[youngSlot]) begin
        fwdHit  = 1'b1;
        fwdData = entryData[youngSlot];
      end else if (match[wrPtr]) begin
        fwdHit  = 1'b1;
        fwdData = entryData[wrPtr];
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: handshakes, ordering, x0 filtering,
// forwarding priority and asynchronous reset.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic [4:0]  inRd;
  logic        wbValid;
  logic        wbReady;
  logic [31:0] wbData;
  logic [4:0]  wbRd;
  logic [4:0]  fwdRd;
  logic        fwdHit;
  logic [31:0] fwdData;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;
  int writeCount = 0;
  logic [31:0] retired[$];

  alu_writeback dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .inValid   (inValid),
    .inReady   (inReady),
    .inData    (inData),
    .inRd      (inRd),
    .wbValid   (wbValid),
    .wbReady   (wbReady),
    .wbData    (wbData),
    .wbRd      (wbRd),
    .fwdRd     (fwdRd),
    .fwdHit    (fwdHit),
    .fwdData   (fwdData),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Record every write the register file would accept.
  always @(posedge clk) begin
    if (reset_n && wbValid && wbReady) begin
      retired.push_back(wbData);
      writeCount++;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; inValid = 1'b0; inData = '0; inRd = '0; wbReady = 1'b0; fwdRd = '0;
    #12;
    checks++; if (wbValid !== 1'b0)    begin errors++; $display("FAIL reset_wbValid: got %b want 0", wbValid); end
    checks++; if (occupancy !== 2'd0)  begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (inReady !== 1'b0)    begin errors++; $display("FAIL reset_inReady_low: got %b want 0", inReady); end
    checks++; if (wbData !== 32'h0)    begin errors++; $display("FAIL reset_wbData: got %h want 0", wbData); end
    checks++; if (wbRd !== 5'd0)       begin errors++; $display("FAIL reset_wbRd: got %0d want 0", wbRd); end
    checks++; if (fwdHit !== 1'b0 || fwdData !== 32'h0) begin errors++; $display("FAIL reset_fwd: got %b/%h want 0/0", fwdHit, fwdData); end
    tick();
    reset_n = 1'b1;
    #1;
    checks++; if (inReady !== 1'b1)    begin errors++; $display("FAIL reset_inReady_release: got %b want 1", inReady); end
  endtask

  task automatic test_single();
    inValid = 1'b1; inRd = 5'd5; inData = 32'h0000002A; wbReady = 1'b0;
    #1;
    checks++; if (wbValid !== 1'b0)    begin errors++; $display("FAIL single_no_passthrough: got %b want 0", wbValid); end
    tick();
    inValid = 1'b0;
    checks++; if (wbValid !== 1'b1)    begin errors++; $display("FAIL single_wbValid: got %b want 1", wbValid); end
    checks++; if (wbRd !== 5'd5)       begin errors++; $display("FAIL single_wbRd: got %0d want 5", wbRd); end
    checks++; if (wbData !== 32'h2A)   begin errors++; $display("FAIL single_wbData: got %h want 0000002a", wbData); end
    checks++; if (occupancy !== 2'd1)  begin errors++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    retired.delete();
    wbReady = 1'b1;
    tick();
    wbReady = 1'b0;
    checks++; if (occupancy !== 2'd0)  begin errors++; $display("FAIL single_drain_occ: got %0d want 0", occupancy); end
    checks++; if (retired.size() != 1 || retired[0] !== 32'h2A) begin errors++; $display("FAIL single_retired: got %0d writes want 1 of 0000002a", retired.size()); end
  endtask

  task automatic test_backpressure();
    wbReady = 1'b0;
    inValid = 1'b1; inRd = 5'd3; inData = 32'h11;
    tick();
    inRd = 5'd4; inData = 32'h22;
    tick();
    inValid = 1'b0;
    checks++; if (occupancy !== 2'd2)  begin errors++; $display("FAIL bp_occ_full: got %0d want 2", occupancy); end
    checks++; if (inReady !== 1'b0)    begin errors++; $display("FAIL bp_inReady_full: got %b want 0", inReady); end
    checks++; if (wbData !== 32'h11)   begin errors++; $display("FAIL bp_head: got %h want 00000011", wbData); end
    // A push attempt while full must be ignored.
    inValid = 1'b1; inRd = 5'd9; inData = 32'h99;
    tick();
    inValid = 1'b0;
    checks++; if (wbData !== 32'h11 || wbRd !== 5'd3) begin errors++; $display("FAIL bp_stable: got %h/%0d want 00000011/3", wbData, wbRd); end
    checks++; if (occupancy !== 2'd2)  begin errors++; $display("FAIL bp_full_push_ignored: got %0d want 2", occupancy); end
    retired.delete();
    wbReady = 1'b1;
    tick();
    checks++; if (inReady !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_free_slot: got ready=%b occ=%0d want 1/1", inReady, occupancy); end
    checks++; if (wbData !== 32'h22 || wbRd !== 5'd4) begin errors++; $display("FAIL bp_second_head: got %h/%0d want 00000022/4", wbData, wbRd); end
    tick();
    wbReady = 1'b0;
    checks++; if (occupancy !== 2'd0)  begin errors++; $display("FAIL bp_drained: got %0d want 0", occupancy); end
    checks++; if (retired.size() != 2 || retired[0] !== 32'h11 || retired[1] !== 32'h22) begin
      errors++; $display("FAIL bp_order: got %0d writes want 00000011 then 00000022", retired.size());
    end
  endtask

  task automatic test_rd_zero();
    inValid = 1'b1; inRd = 5'd0; inData = 32'hFFFFFFFF;
    tick();
    inValid = 1'b0;
    checks++; if (occupancy !== 2'd0)  begin errors++; $display("FAIL rd0_occ: got %0d want 0", occupancy); end
    checks++; if (wbValid !== 1'b0)    begin errors++; $display("FAIL rd0_wbValid: got %b want 0", wbValid); end
  endtask

  task automatic test_forward();
    wbReady = 1'b0;
    // A result being accepted this cycle is not visible to the lookup.
    inValid = 1'b1; inRd = 5'd12; inData = 32'h55; fwdRd = 5'd12;
    #1;
    checks++; if (fwdHit !== 1'b0 || fwdData !== 32'h0) begin errors++; $display("FAIL fwd_same_cycle: got %b/%h want 0/0", fwdHit, fwdData); end
    tick();
    inValid = 1'b0;
    checks++; if (fwdHit !== 1'b1 || fwdData !== 32'h55) begin errors++; $display("FAIL fwd_buffered: got %b/%h want 1/00000055", fwdHit, fwdData); end
    wbReady = 1'b1;
    tick();
    wbReady = 1'b0;
    inValid = 1'b1; inRd = 5'd7; inData = 32'h1;
    tick();
    inData = 32'h2;
    tick();
    inValid = 1'b0; fwdRd = 5'd7;
    #1;
    checks++; if (fwdHit !== 1'b1 || fwdData !== 32'h2) begin errors++; $display("FAIL fwd_youngest: got %b/%h want 1/00000002", fwdHit, fwdData); end
    fwdRd = 5'd0;
    #1;
    checks++; if (fwdHit !== 1'b0 || fwdData !== 32'h0) begin errors++; $display("FAIL fwd_rd0: got %b/%h want 0/0", fwdHit, fwdData); end
    fwdRd = 5'd9;
    #1;
    checks++; if (fwdHit !== 1'b0 || fwdData !== 32'h0) begin errors++; $display("FAIL fwd_nomatch: got %b/%h want 0/0", fwdHit, fwdData); end
    fwdRd = 5'd7;
    wbReady = 1'b1;
    tick();
    wbReady = 1'b0;
    checks++; if (fwdHit !== 1'b1 || fwdData !== 32'h2) begin errors++; $display("FAIL fwd_after_retire: got %b/%h want 1/00000002", fwdHit, fwdData); end
    wbReady = 1'b1;
    tick();
    wbReady = 1'b0;
    checks++; if (fwdHit !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL fwd_empty: got hit=%b occ=%0d want 0/0", fwdHit, occupancy); end
    fwdRd = 5'd0;
  endtask

  task automatic test_back_to_back();
    wbReady = 1'b0;
    inValid = 1'b1; inRd = 5'd10; inData = 32'hAA;
    tick();
    inRd = 5'd11; inData = 32'hBB; wbReady = 1'b1;
    tick();
    inValid = 1'b0; wbReady = 1'b0;
    checks++; if (occupancy !== 2'd1)  begin errors++; $display("FAIL b2b_occ: got %0d want 1", occupancy); end
    checks++; if (wbData !== 32'hBB || wbRd !== 5'd11) begin errors++; $display("FAIL b2b_head: got %h/%0d want 000000bb/11", wbData, wbRd); end
    wbReady = 1'b1;
    tick();
    wbReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    int writesBefore;
    wbReady = 1'b0;
    inValid = 1'b1; inRd = 5'd1; inData = 32'h1;
    tick();
    inRd = 5'd2; inData = 32'h2;
    tick();
    inValid = 1'b0;
    checks++; if (occupancy !== 2'd2)  begin errors++; $display("FAIL rstmid_fill: got %0d want 2", occupancy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (wbValid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL rstmid_async: got wbValid=%b occ=%0d want 0/0", wbValid, occupancy); end
    checks++; if (inReady !== 1'b0)    begin errors++; $display("FAIL rstmid_inReady: got %b want 0", inReady); end
    writesBefore = writeCount;
    reset_n = 1'b1;
    wbReady = 1'b1;
    tick();
    tick();
    wbReady = 1'b0;
    checks++; if (wbValid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL rstmid_after: got wbValid=%b occ=%0d want 0/0", wbValid, occupancy); end
    checks++; if (writeCount != writesBefore) begin errors++; $display("FAIL rstmid_no_writes: got %0d writes want %0d", writeCount, writesBefore); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_rd_zero();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: DATA_WIDTH, default `DATA_WIDTH (global define, 32), width of ALU results and register data.
REQ-002 Parameter: REG_ADDR_WIDTH, default 5, width of destination register index.
REQ-003 Parameter: DEPTH, default 2, buffer entries; only 2 is supported.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 inValid  input  1  ALU result valid.
REQ-007 inReady  output  1  block can accept a result this cycle.
REQ-008 inData  input  DATA_WIDTH  ALU result (sum, product, quotient, remainder or compare flag).
REQ-009 inRd  input  REG_ADDR_WIDTH  destination register index.
REQ-010 wbValid  output  1  register-file write pending.
REQ-011 wbReady  input  1  register-file write port accepts this cycle.
REQ-012 wbData  output  DATA_WIDTH  write data.
REQ-013 wbRd  output  REG_ADDR_WIDTH  write address.
REQ-014 fwdRd  input  REG_ADDR_WIDTH  forwarding lookup register index.
REQ-015 fwdHit  output  1  fwdRd matches a buffered, not-yet-written entry.
REQ-016 fwdData  output  DATA_WIDTH  data of the matching entry.
REQ-017 occupancy  output  2  number of buffered entries (0..2).

Function
REQ-018 Accept occurs on a rising edge with inValid && inReady; retire occurs with wbValid && wbReady.
REQ-019 inReady = (occupancy != 2); depends only on registered state, never on inValid or wbReady.
REQ-020 Accepted results with inRd == 0 are discarded: not enqueued, occupancy unchanged, no write issued.
REQ-021 Entries are retired strictly in acceptance order (FIFO).
REQ-022 wbValid = (occupancy != 0); wbData/wbRd show the oldest entry, driven from registers.
REQ-023 Latency: a result accepted at edge N is presented on wbValid/wbData/wbRd in the cycle after edge N; no same-cycle pass-through from in* to wb*.
REQ-024 While wbValid is high and wbReady low, wbData and wbRd hold stable.
REQ-025 Occupancy 1, simultaneous accept and retire: occupancy stays 1, new entry becomes head next cycle.
REQ-026 Occupancy 2: no accept possible; a retire frees one slot, inReady rises the following cycle.
REQ-027 Occupancy 0, accept: occupancy becomes 1; retire is impossible (wbValid low).
REQ-028 Read and write pointers are 1 bit and wrap modulo 2.
REQ-029 fwdHit/fwdData are combinational over buffered entries; if both match fwdRd, the younger entry wins.
REQ-030 fwdRd == 0 -> fwdHit = 0, fwdData = 0; no match -> fwdHit = 0, fwdData = 0.
REQ-031 Forwarding does not see a result being accepted in the same cycle (inputs are not searched).

Reset
REQ-032 reset_n low asynchronously clears: occupancy 0, pointers 0, wbValid 0, wbData 0, wbRd 0, fwdHit 0, fwdData 0, inReady 1 (after reset release).
REQ-033 Reset mid-operation discards all buffered entries; no write issued for them after reset release.
REQ-034 inReady is held 0 while reset_n is low.

Structure
REQ-035 DATA_WIDTH stays in globalVariables.v; REG_ADDR_WIDTH define is added there too.
REQ-036 One sub-module, alu_wb_fifo: 2-entry storage, pointers, occupancy and per-entry match outputs; alu_writeback adds rd==0 filtering, handshakes and youngest-match selection.

Verification
REQ-037 Reset, then inValid=1, inRd=5, inData=0x0000002A -> next cycle wbValid=1, wbRd=5, wbData=0x2A, occupancy=1.
REQ-038 wbReady=0, accept rd=3 data=0x11 then rd=4 data=0x22 -> occupancy=2, inReady=0, wbData=0x11 stable; wbReady=1 -> 0x11 then 0x22 retired in order.
REQ-039 Accept inRd=0, inData=0xFFFFFFFF -> occupancy stays 0, wbValid stays 0.
REQ-040 Buffer rd=7 data=0x1 then rd=7 data=0x2 (wbReady=0), fwdRd=7 -> fwdHit=1, fwdData=0x2; fwdRd=0 -> fwdHit=0.
REQ-041 Occupancy 1, inValid=1 and wbReady=1 same edge -> occupancy stays 1, new entry at head next cycle.
REQ-042 Occupancy 2, pulse reset_n low mid-cycle -> wbValid=0, occupancy=0 immediately; no writes after release.
